// File: rtl/bus_memory_responder_pkg.sv
// Shared encodings for the bus memory responder: access direction, FSM states, defaults.
package bus_memory_responder_pkg;

  localparam logic ACC_READ  = 1'b0;
  localparam logic ACC_WRITE = 1'b1;

  localparam int unsigned STATE_W    = 2;
  localparam int unsigned WAIT_CNT_W = 4;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

  localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hFF;

endpackage

// File: rtl/bus_memory_responder_resp_byte_ram.sv
// Byte RAM with one shared address port: synchronous write, combinational read.
module resp_byte_ram #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] mem_q [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_c = mem_q[addr_i];

endmodule

// File: rtl/bus_memory_responder.sv
// Memory-side bus responder: accepts one access, waits WAIT_STATES cycles, pulses ready.
module bus_memory_responder
  import bus_memory_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned MEM_BITS    = 12,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [7:0]  OPEN_BUS    = OPEN_BUS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bus_req,
  input  logic [ADDR_W-1:0]   address,
  input  logic                read_write,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  output logic                ready,
  output logic                bus_err,
  output logic                busy,
  input  logic                load_en,
  input  logic [MEM_BITS-1:0] load_addr,
  input  logic [7:0]          load_data
);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [MEM_BITS-1:0]   addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  mapped_q, mapped_d;
  logic                  ready_q, ready_d;
  logic                  bus_err_q, bus_err_d;
  logic                  busy_q, busy_d;
  logic [7:0]            data_out_q, data_out_d;

  logic                  addr_in_map;
  logic                  ram_we;
  logic [MEM_BITS-1:0]   ram_addr;
  logic [7:0]            ram_wdata;
  logic [7:0]            ram_rdata;

  // Full-width decode so high addresses never alias into the RAM.
  assign addr_in_map = ~|(address >> MEM_BITS);

  // State register and captured access fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      mapped_q   <= 1'b0;
      ready_q    <= 1'b0;
      bus_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      mapped_q   <= mapped_d;
      ready_q    <= ready_d;
      bus_err_q  <= bus_err_d;
      busy_q     <= busy_d;
      data_out_q <= data_out_d;
    end
  end

  // Next-state, capture and registered-status logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    wdata_d  = wdata_q;
    mapped_d = mapped_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_req) begin
          addr_d   = address[MEM_BITS-1:0];
          rw_d     = read_write;
          wdata_d  = data_in;
          mapped_d = addr_in_map;
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_CNT_W'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        if (!bus_req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WAIT_CNT_W'(1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d   = (state_d == ST_RESP);
    bus_err_d = ready_d & ~mapped_d;
    busy_d    = (state_d != ST_IDLE);
  end

  // Read data is loaded on the edge entering RESP so it is valid alongside ready.
  always_comb begin
    data_out_d = data_out_q;
    if (ready_d && (rw_d == ACC_READ)) begin
      data_out_d = mapped_d ? ram_rdata : OPEN_BUS;
    end
  end

  // Single RAM port shared by bus accept/read, bus write commit and preload.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      if (bus_req) begin
        ram_addr = address[MEM_BITS-1:0];
      end else if (load_en) begin
        ram_we    = 1'b1;
        ram_addr  = load_addr;
        ram_wdata = load_data;
      end
    end else if ((state_q == ST_RESP) && (rw_q == ACC_WRITE) && mapped_q) begin
      ram_we = 1'b1;
    end
  end

  resp_byte_ram #(
    .ADDR_W (MEM_BITS)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_c (ram_rdata)
  );

  assign data_out = data_out_q;
  assign ready    = ready_q;
  assign bus_err  = bus_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench: three responders (WAIT_STATES 0, 1, 3) sharing one stimulus bus.
module tb_bus_memory_responder;
  import bus_memory_responder_pkg::*;

  logic        clk;
  logic        rst;
  logic        bus_req;
  logic [15:0] address;
  logic        read_write;
  logic [7:0]  data_in;
  logic        load_en;
  logic [11:0] load_addr;
  logic [7:0]  load_data;

  logic       ready_w   [3];
  logic       bus_err_w [3];
  logic       busy_w    [3];
  logic [7:0] dout_w    [3];

  int n_checks;
  int n_errors;

  bus_memory_responder #(.WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .rst(rst), .bus_req(bus_req), .address(address), .read_write(read_write),
    .data_in(data_in), .data_out(dout_w[0]), .ready(ready_w[0]), .bus_err(bus_err_w[0]),
    .busy(busy_w[0]), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  bus_memory_responder #(.WAIT_STATES(1)) u_dut_ws1 (
    .clk(clk), .rst(rst), .bus_req(bus_req), .address(address), .read_write(read_write),
    .data_in(data_in), .data_out(dout_w[1]), .ready(ready_w[1]), .bus_err(bus_err_w[1]),
    .busy(busy_w[1]), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  bus_memory_responder #(.WAIT_STATES(3)) u_dut_ws3 (
    .clk(clk), .rst(rst), .bus_req(bus_req), .address(address), .read_write(read_write),
    .data_in(data_in), .data_out(dout_w[2]), .ready(ready_w[2]), .bus_err(bus_err_w[2]),
    .busy(busy_w[2]), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge, bus idle.
  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  // Called on a negedge; the following posedge is acceptance edge 0.
  // lat counts negedge samples after edge 0 until ready of the selected responder.
  task automatic xfer(input int sel, input logic [15:0] a, input logic rw, input logic [7:0] d,
                      input bit keep, output logic [7:0] rd, output logic err, output int lat);
    bit seen;
    seen       = 1'b0;
    rd         = '0;
    err        = 1'b0;
    lat        = 0;
    bus_req    = 1'b1;
    address    = a;
    read_write = rw;
    data_in    = d;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (ready_w[sel]) begin
        seen = 1'b1;
        lat  = k;
        rd   = dout_w[sel];
        err  = bus_err_w[sel];
      end
    end
    if (!keep) bus_req = 1'b0;
    check_eq("ready_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    logic [7:0] rd;
    logic       err;
    int         lat;
    int         pulses;

    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    bus_req    = 1'b0;
    address    = '0;
    read_write = ACC_READ;
    data_in    = '0;
    load_en    = 1'b0;
    load_addr  = '0;
    load_data  = '0;

    #3 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_ready%0d", i), 32'(ready_w[i]), 32'd0);
      check_eq($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 32'd0);
      check_eq($sformatf("rst_err%0d", i), 32'(bus_err_w[i]), 32'd0);
      check_eq($sformatf("rst_dout%0d", i), 32'(dout_w[i]), 32'h00);
    end
    idle(2);
    rst = 1'b1;
    @(negedge clk);

    preload(12'h123, 8'hA5);
    preload(12'h000, 8'h5A);
    preload(12'h010, 8'h22);
    preload(12'h200, 8'h44);

    // Basic read with one wait state.
    xfer(1, 16'h0123, ACC_READ, 8'h00, 1'b0, rd, err, lat);
    check_eq("rd123_lat", 32'(lat), 32'd2);
    check_eq("rd123_data", 32'(rd), 32'hA5);
    check_eq("rd123_err", 32'(err), 32'd0);
    idle(5);

    // Back-to-back write then read of the top RAM byte.
    xfer(1, 16'h0FFF, ACC_WRITE, 8'h3C, 1'b1, rd, err, lat);
    check_eq("wrfff_lat", 32'(lat), 32'd2);
    check_eq("wrfff_err", 32'(err), 32'd0);
    check_eq("wr_dout_hold", 32'(rd), 32'hA5);
    xfer(1, 16'h0FFF, ACC_READ, 8'h00, 1'b0, rd, err, lat);
    check_eq("b2b_spacing", 32'(lat), 32'd3);
    check_eq("rdfff_data", 32'(rd), 32'h3C);
    idle(5);

    // Unmapped accesses.
    xfer(1, 16'h1000, ACC_READ, 8'h00, 1'b0, rd, err, lat);
    check_eq("rd1000_data", 32'(rd), 32'hFF);
    check_eq("rd1000_err", 32'(err), 32'd1);
    idle(5);
    xfer(1, 16'h1000, ACC_WRITE, 8'h77, 1'b0, rd, err, lat);
    check_eq("wr1000_err", 32'(err), 32'd1);
    idle(5);
    xfer(1, 16'h0000, ACC_READ, 8'h00, 1'b0, rd, err, lat);
    check_eq("rd0000_noalias", 32'(rd), 32'h5A);
    check_eq("rd0000_err", 32'(err), 32'd0);
    idle(5);
    xfer(1, 16'hF123, ACC_READ, 8'h00, 1'b0, rd, err, lat);
    check_eq("rdf123_data", 32'(rd), 32'hFF);
    check_eq("rdf123_err", 32'(err), 32'd1);
    idle(5);

    // Abort during WAIT on the three-wait-state responder.
    pulses     = 0;
    bus_req    = 1'b1;
    address    = 16'h0010;
    read_write = ACC_WRITE;
    data_in    = 8'h11;
    repeat (2) begin
      @(negedge clk);
      if (ready_w[2]) pulses++;
    end
    bus_req = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready_w[2]) pulses++;
    end
    check_eq("abort_no_ready", 32'(pulses), 32'd0);
    check_eq("abort_idle", 32'(busy_w[2]), 32'd0);
    xfer(2, 16'h0010, ACC_READ, 8'h00, 1'b0, rd, err, lat);
    check_eq("rd0010_lat", 32'(lat), 32'd4);
    check_eq("abort_no_commit", 32'(rd), 32'h22);
    idle(5);

    // Reset while one responder waits and another is responding.
    bus_req    = 1'b1;
    address    = 16'h0123;
    read_write = ACC_READ;
    repeat (2) @(negedge clk);
    check_eq("pre_rst_busy3", 32'(busy_w[2]), 32'd1);
    check_eq("pre_rst_ready1", 32'(ready_w[1]), 32'd1);
    #1 rst = 1'b0;
    #1;
    check_eq("rst_now_busy3", 32'(busy_w[2]), 32'd0);
    check_eq("rst_now_ready3", 32'(ready_w[2]), 32'd0);
    check_eq("rst_now_err3", 32'(bus_err_w[2]), 32'd0);
    check_eq("rst_now_ready1", 32'(ready_w[1]), 32'd0);
    check_eq("rst_now_busy1", 32'(busy_w[1]), 32'd0);
    bus_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    xfer(2, 16'h0123, ACC_READ, 8'h00, 1'b0, rd, err, lat);
    check_eq("post_rst_lat", 32'(lat), 32'd4);
    check_eq("post_rst_data", 32'(rd), 32'hA5);
    idle(5);

    // Reset during a write response discards the write.
    bus_req    = 1'b1;
    address    = 16'h0123;
    read_write = ACC_WRITE;
    data_in    = 8'hEE;
    repeat (2) @(negedge clk);
    check_eq("wr_resp_ready1", 32'(ready_w[1]), 32'd1);
    #1 rst = 1'b0;
    #1;
    check_eq("rst_drop_ready1", 32'(ready_w[1]), 32'd0);
    bus_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    xfer(1, 16'h0123, ACC_READ, 8'h00, 1'b0, rd, err, lat);
    check_eq("rst_no_commit", 32'(rd), 32'hA5);
    idle(5);

    // Zero wait states, preload colliding with a bus request.
    load_en   = 1'b1;
    load_addr = 12'h200;
    load_data = 8'h99;
    xfer(0, 16'h0200, ACC_READ, 8'h00, 1'b0, rd, err, lat);
    load_en = 1'b0;
    check_eq("ws0_lat", 32'(lat), 32'd1);
    check_eq("ws0_data", 32'(rd), 32'h44);
    check_eq("ws0_err", 32'(err), 32'd0);
    idle(5);
    xfer(0, 16'h0200, ACC_READ, 8'h00, 1'b0, rd, err, lat);
    check_eq("preload_ignored", 32'(rd), 32'h44);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
